hunt_game_ctrl: RTL
===================

// Module: hunt_game_ctrl
// PURPOSE
// Game-state sequencer feeding the frame compositor: counts shots, hit-tests the aim against the duck box,
// times the post-shot flash and latches win/lose. Drives press_count, flag_shoot and flag into the compositor,
// and freeze/respawn controls into the duck-motion block. One instance at top level, pixel-clock domain.
// PARAMETERS
// MAX_SHOTS     3   shots per round; press_count saturates here
// FLASH_FRAMES  30  frames flag_shoot stays high after each shot (>=1)
// DUCK_W        71  duck box width; hit when blkpos_x < px < blkpos_x+DUCK_W
// DUCK_H        54  duck box height; hit when blkpos_y < py < blkpos_y+DUCK_H
// AIM_CX        15  aim hotspot x offset from sniper_x
// AIM_CY        13  aim hotspot y offset from sniper_y
// PORTS
// clk            in   1   pixel clock
// rst_n          in   1   asynchronous, active-low reset
// frame_tick     in   1   one-cycle pulse per frame (start of vblank)
// shoot_btn      in   1   synchronised, debounced trigger level
// restart_btn    in   1   synchronised, debounced restart level
// sniper_x/_y    in   11  aim sprite top-left
// blkpos_x/_y    in   11  duck sprite top-left
// press_count    out  2   shots used this round, 0..MAX_SHOTS
// flag_shoot     out  1   flash window active after a shot
// flag           out  1   1 = duck hit this round (win)
// duck_freeze    out  1   hold duck position (FLASH or OVER)
// duck_respawn   out  1   one-cycle pulse: restart duck at spawn point
// BEHAVIOUR
// - Reset (async assert, sync release): state PLAY, press_count=0, flag_shoot=0, flag=0, duck_freeze=0,
//   duck_respawn=0, frame counter=0. Reset mid-FLASH aborts the flash; no pulse is emitted.
// - Rising edges of shoot_btn/restart_btn detected internally (1-cycle registered compare); a held level = one event.
// - States: PLAY, FLASH, OVER. All outputs registered; visible 1 cycle after the edge-detect cycle.
// - PLAY + shoot edge: sample coords that same cycle; hit = (px,py) strictly inside duck box, where
//   px=sniper_x+AIM_CX, py=sniper_y+AIM_CY computed at 12 bits (no wrap; blkpos+DUCK_W also 12 bits).
//   press_count += 1 (saturating MAX_SHOTS); if hit: flag<=1 and press_count<=MAX_SHOTS.
//   -> FLASH, flag_shoot=1, duck_freeze=1, frame counter cleared.
// - FLASH: shoot edges ignored. Counter increments on frame_tick; on the tick where counter==FLASH_FRAMES-1:
//   flag_shoot<=0; if press_count==MAX_SHOTS -> OVER (duck_freeze stays 1), else -> PLAY (duck_freeze<=0).
//   A tick in the shot cycle itself is not counted.
// - OVER: shoot edges ignored; outputs hold. Compositor shows result (press_count==MAX_SHOTS && !flag_shoot).
// - Restart edge, any state: -> PLAY, press_count=0, flag=0, flag_shoot=0, duck_freeze=0, counter=0,
//   duck_respawn=1 for one cycle. Restart wins over a same-cycle shoot edge (shot discarded).
// - Shoot edge coinciding with frame_tick in PLAY: shot processed normally; the tick is not counted.
// - flag never cleared except by restart/reset; press_count never decrements otherwise.
// STRUCTURE
// - Shared package hunt_pkg: game_state_t enum {PLAY, FLASH, OVER}, DUCK_W/DUCK_H/AIM_CX/AIM_CY
//   constants (shared with compositor and motion blocks), 12-bit coord_ext_t.
// - Sub-module edge_rise (registered rising-edge detector), instantiated for shoot_btn and restart_btn.
// - Frame counter width $clog2(FLASH_FRAMES+1); hit test a separate combinational function in this module.
// TESTING
// 1 Reset: assert rst_n=0 mid-FLASH -> all outputs 0, state PLAY immediately, no respawn pulse.
// 2 Miss x3: duck (100,100), aim (400,400), three shots each followed by 30 ticks -> press_count 1,2,3;
//   flag_shoot high exactly 30 ticks each; after third flash flag=0, duck_freeze=1, state OVER.
// 3 Hit: duck (200,150), aim (200,150) -> hotspot (215,163) inside -> flag=1, press_count=3, OVER after 30 ticks.
// 4 Edge: hotspot px=blkpos_x+71 (on right edge) -> miss; px=blkpos_x+70 -> hit; sniper_x=2040 -> no wrap, miss.
// 5 Ignored/held: shoot held high 100 cycles = one shot; shoot edges during FLASH/OVER leave press_count unchanged.
// 6 Restart: restart edge same cycle as shoot edge in PLAY with press_count=2 -> press_count=0, flag=0,
//   duck_respawn high exactly 1 cycle, no FLASH entered.

Source files
------------

// File: rtl/hunt_pkg.sv
// Shared game-wide types and sprite geometry for the hunt game blocks
// (controller, compositor, duck motion).
package hunt_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    OVER  = 2'd2
  } game_state_t;

  // One bit wider than screen coordinates so that sprite offsets never wrap.
  typedef logic [11:0] coord_ext_t;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned DUCK_W  = 71;
  localparam int unsigned DUCK_H  = 54;
  localparam int unsigned AIM_CX  = 15;
  localparam int unsigned AIM_CY  = 13;

endpackage

// File: rtl/hunt_game_ctrl_if.sv
// Signal bundle between the game controller and its neighbours
// (input conditioning, frame compositor, duck motion).
interface hunt_game_ctrl_if;
  // Buttons are debounced levels sampled on every clk, frame_tick and
  // duck_respawn are single-cycle pulses, and nothing here has back-pressure:
  // every value is consumed on the cycle it is presented.
  logic                 frame_tick;
  logic                 shoot_btn;
  logic                 restart_btn;
  logic [10:0]          sniper_x;
  logic [10:0]          sniper_y;
  logic [10:0]          blkpos_x;
  logic [10:0]          blkpos_y;
  logic [1:0]           press_count;
  logic                 flag_shoot;
  logic                 flag;
  logic                 duck_freeze;
  logic                 duck_respawn;
  hunt_pkg::game_state_t state_dbg;

  modport master (
    output frame_tick, shoot_btn, restart_btn,
    output sniper_x, sniper_y, blkpos_x, blkpos_y,
    input  press_count, flag_shoot, flag, duck_freeze, duck_respawn, state_dbg
  );

  modport slave (
    input  frame_tick, shoot_btn, restart_btn,
    input  sniper_x, sniper_y, blkpos_x, blkpos_y,
    output press_count, flag_shoot, flag, duck_freeze, duck_respawn, state_dbg
  );
endinterface

// File: rtl/hunt_game_ctrl_edge_rise.sv
// Rising-edge detector: a held level produces exactly one pulse on the
// first cycle it is seen high.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/hunt_game_ctrl.sv
// Game-state sequencer: counts shots, hit-tests the aim hotspot against the
// duck box, times the post-shot flash and latches the round result.
module hunt_game_ctrl
  import hunt_pkg::*;
#(
  parameter int unsigned MAX_SHOTS    = 3,
  parameter int unsigned FLASH_FRAMES = 30
) (
  input  logic            clk,
  input  logic            rst_n,
  hunt_game_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [1:0]       MAX_PC     = 2'(MAX_SHOTS);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FLASH_FRAMES - 1);

  game_state_t      state;
  logic [1:0]       press_count;
  logic             flag_shoot;
  logic             flag;
  logic             duck_freeze;
  logic             duck_respawn;
  logic [CNT_W-1:0] frame_cnt;
  logic             shoot_edge;
  logic             restart_edge;

  edge_rise u_shoot_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (bus.shoot_btn),
    .rise  (shoot_edge)
  );

  edge_rise u_restart_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (bus.restart_btn),
    .rise  (restart_edge)
  );

  // Strictly-inside test; all sums are 12 bits so a hotspot past the right
  // screen edge cannot wrap around into a duck at the left.
  function automatic logic hit_test(input logic [10:0] sx, input logic [10:0] sy,
                                    input logic [10:0] bx, input logic [10:0] by);
    coord_ext_t px, py, bx_lo, by_lo, bx_hi, by_hi;
    px    = {1'b0, sx} + coord_ext_t'(AIM_CX);
    py    = {1'b0, sy} + coord_ext_t'(AIM_CY);
    bx_lo = {1'b0, bx};
    by_lo = {1'b0, by};
    bx_hi = bx_lo + coord_ext_t'(DUCK_W);
    by_hi = by_lo + coord_ext_t'(DUCK_H);
    return (px > bx_lo) && (px < bx_hi) && (py > by_lo) && (py < by_hi);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PLAY;
      press_count  <= 2'd0;
      flag_shoot   <= 1'b0;
      flag         <= 1'b0;
      duck_freeze  <= 1'b0;
      duck_respawn <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      duck_respawn <= 1'b0;
      // Restart has priority over everything, including a same-cycle shot.
      if (restart_edge) begin
        state        <= PLAY;
        press_count  <= 2'd0;
        flag_shoot   <= 1'b0;
        flag         <= 1'b0;
        duck_freeze  <= 1'b0;
        duck_respawn <= 1'b1;
        frame_cnt    <= '0;
      end else begin
        case (state)
          PLAY: begin
            if (shoot_edge) begin
              state       <= FLASH;
              flag_shoot  <= 1'b1;
              duck_freeze <= 1'b1;
              frame_cnt   <= '0;
              if (hit_test(bus.sniper_x, bus.sniper_y, bus.blkpos_x, bus.blkpos_y)) begin
                flag        <= 1'b1;
                press_count <= MAX_PC;
              end else if (press_count != MAX_PC) begin
                press_count <= press_count + 2'd1;
              end
            end
          end
          FLASH: begin
            if (bus.frame_tick) begin
              if (frame_cnt == LAST_FRAME) begin
                flag_shoot <= 1'b0;
                frame_cnt  <= '0;
                if (press_count == MAX_PC) begin
                  state <= OVER;
                end else begin
                  state       <= PLAY;
                  duck_freeze <= 1'b0;
                end
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end
          OVER: ;
          default: state <= PLAY;
        endcase
      end
    end
  end

  assign bus.press_count  = press_count;
  assign bus.flag_shoot   = flag_shoot;
  assign bus.flag         = flag;
  assign bus.duck_freeze  = duck_freeze;
  assign bus.duck_respawn = duck_respawn;
  assign bus.state_dbg    = state;

endmodule
